// File: rtl/pig_pkg.sv
// Shared types and constants for the Pig game turn controller.
// Holds the FSM state encoding, dice value limits and default sizing.
package pig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ROLLING = 3'd1,
    ST_EVAL    = 3'd2,
    ST_BANK    = 3'd3,
    ST_SWITCH  = 3'd4,
    ST_WIN     = 3'd5
  } state_t;

  localparam logic [3:0] ROLL_MIN = 4'd1;
  localparam logic [3:0] ROLL_MAX = 4'd6;
  localparam logic [3:0] BUST_VAL = 4'd1;

  localparam int DEF_TARGET  = 100;
  localparam int DEF_SCORE_W = 8;

endpackage

// File: rtl/sat_add.sv
// Saturating unsigned adder: o_sum = min(i_a + i_b, 2^A_W-1).
// Ports: i_a (A_W bits), i_b (B_W bits, B_W <= A_W), o_sum (A_W bits).
module sat_add #(
  parameter int A_W = 8,
  parameter int B_W = 4
) (
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  output logic [A_W-1:0] o_sum
);

  logic [A_W:0] w_full;

  assign w_full = {1'b0, i_a} + {{(A_W+1-B_W){1'b0}}, i_b};
  assign o_sum  = w_full[A_W] ? '1 : w_full[A_W-1:0];

endmodule

// File: rtl/pig_turn_ctrl.sv
// Pig game turn sequencer: dice enable, turn total, banking, winner.
// Ports: clock/reset, btn_roll/btn_hold/new_game/roll_val in; scores, status out.
module pig_turn_ctrl
  import pig_pkg::*;
#(
  parameter int TARGET  = DEF_TARGET,
  parameter int SCORE_W = DEF_SCORE_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_roll,
  input  logic               btn_hold,
  input  logic               new_game,
  input  logic [3:0]         roll_val,
  output logic               en_roll,
  output logic               cur_player,
  output logic [SCORE_W-1:0] turn_total,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [3:0]         last_roll,
  output logic               bust,
  output logic               roll_err,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state_o
);

  if (TARGET > (2**SCORE_W) - 1) begin : g_bad_target
    $error("pig_turn_ctrl: TARGET does not fit in SCORE_W");
  end

  localparam logic [SCORE_W-1:0] L_TARGET = SCORE_W'(TARGET);

  state_t             r_state;
  logic               r_player;
  logic [SCORE_W-1:0] r_turn;
  logic [SCORE_W-1:0] r_score0;
  logic [SCORE_W-1:0] r_score1;
  logic [3:0]         r_last;
  logic               r_bust;
  logic               r_err;
  logic               r_winner;

  logic [SCORE_W-1:0] w_turn_sum;
  logic [SCORE_W-1:0] w_cur_score;
  logic [SCORE_W-1:0] w_bank_sum;
  logic               w_legal;

  assign w_cur_score = r_player ? r_score1 : r_score0;
  assign w_legal     = (roll_val >= ROLL_MIN) && (roll_val <= ROLL_MAX);

  sat_add #(.A_W(SCORE_W), .B_W(4)) u_turn_add (
    .i_a   (r_turn),
    .i_b   (roll_val),
    .o_sum (w_turn_sum)
  );

  sat_add #(.A_W(SCORE_W), .B_W(SCORE_W)) u_bank_add (
    .i_a   (w_cur_score),
    .i_b   (r_turn),
    .o_sum (w_bank_sum)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_player <= 1'b0;
      r_turn   <= '0;
      r_score0 <= '0;
      r_score1 <= '0;
      r_last   <= '0;
      r_bust   <= 1'b0;
      r_err    <= 1'b0;
      r_winner <= 1'b0;
    end else if (new_game) begin
      r_state  <= ST_IDLE;
      r_player <= 1'b0;
      r_turn   <= '0;
      r_score0 <= '0;
      r_score1 <= '0;
      r_last   <= '0;
      r_bust   <= 1'b0;
      r_err    <= 1'b0;
      r_winner <= 1'b0;
    end else begin
      r_bust <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (btn_roll)
            r_state <= ST_ROLLING;
          else if (btn_hold && (r_turn != '0))
            r_state <= ST_BANK;
        end
        ST_ROLLING: begin
          if (!btn_roll)
            r_state <= ST_EVAL;
        end
        ST_EVAL: begin
          // dice is stopped here, so roll_val is settled
          r_last <= roll_val;
          if (roll_val == BUST_VAL) begin
            r_bust  <= 1'b1;
            r_turn  <= '0;
            r_state <= ST_SWITCH;
          end else if (w_legal) begin
            r_turn  <= w_turn_sum;
            r_state <= ST_IDLE;
          end else begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_BANK: begin
          if (r_player)
            r_score1 <= w_bank_sum;
          else
            r_score0 <= w_bank_sum;
          r_turn <= '0;
          if (w_bank_sum >= L_TARGET) begin
            r_winner <= r_player;
            r_state  <= ST_WIN;
          end else begin
            r_state <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          r_player <= ~r_player;
          r_turn   <= '0;
          r_state  <= ST_IDLE;
        end
        ST_WIN: begin
          r_state <= ST_WIN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign en_roll    = (r_state == ST_ROLLING);
  assign game_over  = (r_state == ST_WIN);
  assign cur_player = r_player;
  assign turn_total = r_turn;
  assign score0     = r_score0;
  assign score1     = r_score1;
  assign last_roll  = r_last;
  assign bust       = r_bust;
  assign roll_err   = r_err;
  assign winner     = r_winner;
  assign state_o    = r_state;

endmodule

// File: tb/tb_pig_turn_ctrl.sv
// Self-checking bench for pig_turn_ctrl against a game-level model.
// Directed scenarios plus a randomized roll/hold phase.
module tb_pig_turn_ctrl;

  localparam int TGT  = 100;
  localparam int SMAX = 255;

  logic       clock;
  logic       reset;
  logic       btn_roll;
  logic       btn_hold;
  logic       new_game;
  logic [3:0] roll_val;
  logic       en_roll;
  logic       cur_player;
  logic [7:0] turn_total;
  logic [7:0] score0;
  logic [7:0] score1;
  logic [3:0] last_roll;
  logic       bust;
  logic       roll_err;
  logic       game_over;
  logic       winner;
  logic [2:0] state_o;

  pig_turn_ctrl #(.TARGET(TGT), .SCORE_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_roll   (btn_roll),
    .btn_hold   (btn_hold),
    .new_game   (new_game),
    .roll_val   (roll_val),
    .en_roll    (en_roll),
    .cur_player (cur_player),
    .turn_total (turn_total),
    .score0     (score0),
    .score1     (score1),
    .last_roll  (last_roll),
    .bust       (bust),
    .roll_err   (roll_err),
    .game_over  (game_over),
    .winner     (winner),
    .state_o    (state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // game-level reference state
  int m_player;
  int m_turn;
  int m_score[2];
  int m_last;
  int m_over;
  int m_winner;

  function automatic int sat(input int x);
    return (x > SMAX) ? SMAX : x;
  endfunction

  task automatic m_clear();
    m_player = 0; m_turn = 0;
    m_score[0] = 0; m_score[1] = 0;
    m_last = 0; m_over = 0; m_winner = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".player"}, 32'(cur_player), 32'(m_player));
    chk({tag, ".turn"},   32'(turn_total), 32'(m_turn));
    chk({tag, ".score0"}, 32'(score0),     32'(m_score[0]));
    chk({tag, ".score1"}, 32'(score1),     32'(m_score[1]));
    chk({tag, ".last"},   32'(last_roll),  32'(m_last));
    chk({tag, ".over"},   32'(game_over),  32'(m_over));
    chk({tag, ".winner"}, 32'(winner),     32'(m_winner));
  endtask

  // hold roll for n cycles, then present v as the settled value
  task automatic do_roll(input int n, input logic [3:0] v,
                         input logic hold_too);
    int  cnt;
    int  vi;
    logic e_bust, e_err;
    cnt = 0;
    vi  = int'(v);
    @(negedge clock);
    btn_roll = 1'b1; btn_hold = hold_too;
    roll_val = 4'($urandom_range(1, 6));
    repeat (n) begin
      @(negedge clock);
      if (en_roll) cnt++;
      roll_val = 4'($urandom_range(1, 6));
    end
    btn_roll = 1'b0; btn_hold = 1'b0; roll_val = v;
    if (m_over != 0) begin
      chk("win_roll_en", 32'(cnt), 32'd0);
      repeat (2) @(negedge clock);
      chk("win_roll_en2", 32'(en_roll), 32'd0);
      check_all("win_roll");
      return;
    end
    chk("en_roll_len", 32'(cnt), 32'(n));
    @(negedge clock);
    chk("eval_en_off", 32'(en_roll), 32'd0);
    @(negedge clock);
    e_bust = (vi == 1);
    e_err  = (vi < 1) || (vi > 6);
    m_last = vi;
    if (e_bust) m_turn = 0;
    else if (!e_err) m_turn = sat(m_turn + vi);
    chk("bust_pulse", 32'(bust), 32'(e_bust));
    chk("err_pulse",  32'(roll_err), 32'(e_err));
    check_all("roll");
    @(negedge clock);
    chk("bust_drop", 32'(bust), 32'd0);
    chk("err_drop",  32'(roll_err), 32'd0);
    if (e_bust) begin
      m_player = 1 - m_player;
      check_all("bust_sw");
    end
  endtask

  task automatic do_hold();
    int s;
    @(negedge clock);
    btn_hold = 1'b1;
    @(negedge clock);
    btn_hold = 1'b0;
    if ((m_over != 0) || (m_turn == 0)) begin
      repeat (2) @(negedge clock);
      chk("hold_ign_en", 32'(en_roll), 32'd0);
      check_all("hold_ign");
      return;
    end
    @(negedge clock);
    s = sat(m_score[m_player] + m_turn);
    m_score[m_player] = s;
    m_turn = 0;
    if (s >= TGT) begin
      m_over = 1; m_winner = m_player;
    end
    check_all("bank");
    if (m_over == 0) begin
      @(negedge clock);
      m_player = 1 - m_player;
      check_all("switch");
    end
  endtask

  task automatic do_new_game();
    @(negedge clock);
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
    m_clear();
    check_all("newgame");
    chk("newgame.en", 32'(en_roll), 32'd0);
  endtask

  initial begin
    btn_roll = 1'b0; btn_hold = 1'b0; new_game = 1'b0;
    roll_val = 4'd0; reset = 1'b1;
    m_clear();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_all("reset");
    chk("reset.en",   32'(en_roll),  32'd0);
    chk("reset.bust", 32'(bust),     32'd0);
    chk("reset.err",  32'(roll_err), 32'd0);

    // first roll: 5 cycles, settles on 4
    do_roll(5, 4'd4, 1'b0);
    do_roll(2, 4'd6, 1'b0);
    do_roll(3, 4'd3, 1'b0);
    chk("acc13", 32'(turn_total), 32'd13);
    do_hold();
    chk("bank13", 32'(score0), 32'd13);

    // player 1 builds 9 then busts
    do_roll(1, 4'd4, 1'b0);
    do_roll(2, 4'd5, 1'b0);
    do_roll(1, 4'd1, 1'b0);
    chk("bust_s1", 32'(score1), 32'd0);

    // hold with empty turn is ignored
    do_hold();

    // roll and hold together: roll wins
    do_roll(2, 4'd2, 1'b1);

    // illegal values
    do_roll(1, 4'd0, 1'b0);
    do_roll(1, 4'd7, 1'b0);

    // randomized play
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_hold();
      else
        do_roll(int'($urandom_range(1, 4)),
                4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    // directed win at exactly TARGET
    do_new_game();
    for (int i = 0; i < 15; i++) do_roll(1, 4'd6, 1'b0);
    do_roll(1, 4'd5, 1'b0);
    do_hold();
    chk("s0_95", 32'(score0), 32'd95);
    do_roll(1, 4'd1, 1'b0);
    do_roll(1, 4'd5, 1'b0);
    do_hold();
    chk("win_over", 32'(game_over), 32'd1);
    chk("win_s0",   32'(score0),    32'd100);
    do_roll(2, 4'd3, 1'b0);
    do_hold();
    do_new_game();

    // saturation of turn total and banked score
    do_roll(1, 4'd2, 1'b0);
    do_hold();
    do_roll(1, 4'd1, 1'b0);
    for (int i = 0; i < 43; i++) do_roll(1, 4'd6, 1'b0);
    chk("turn_sat", 32'(turn_total), 32'd255);
    do_hold();
    chk("score_sat", 32'(score0), 32'd255);

    // async reset in the middle of a roll
    do_new_game();
    @(negedge clock);
    btn_roll = 1'b1;
    repeat (2) @(negedge clock);
    chk("pre_rst_en", 32'(en_roll), 32'd1);
    #2 reset = 1'b1;
    #1;
    m_clear();
    chk("async_en", 32'(en_roll), 32'd0);
    check_all("async");
    @(negedge clock);
    btn_roll = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check_all("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
